pcie_tx_credit_gate: RTL and testbench

//  Parametrised next-generation TX flow-control credit tracker for the PCIe app TX path.

---
 rtl/pcie_tx_credit_gate.sv | 186 ++++++++++++++++++
 tb/tb_pcie_tx_credit_gate.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_credit_gate.sv
// PCIe TX flow-control credit gate: per-type P/NP/CPL limits, consumed counters, req/gnt gating.
// Optional per-type stall-cycle statistics are enabled by defining TX_CREDIT_STALL_STATS_EN.
module pcie_tx_credit_gate #(
  parameter int HDR_W  = 8,
  parameter int DAT_W  = 12,
  parameter int STAT_W = 16
) (
  input  logic                i_Clk,
  input  logic                i_SClr,
  input  logic                i_LimLoad,
  input  logic [3*HDR_W-1:0]  i_LimHdr,
  input  logic [3*DAT_W-1:0]  i_LimDat,
  input  logic [5:0]          i_LimInf,
  input  logic [5:0]          i_HipCons1,
  input  logic                i_ReqVal,
  input  logic [1:0]          i_ReqType,
  input  logic [DAT_W-1:0]    i_ReqDat,
  output logic                o_ReqGnt,
  output logic [3*HDR_W-1:0]  o_ConsHdr,
  output logic [3*DAT_W-1:0]  o_ConsDat,
  output logic [3*HDR_W-1:0]  o_AvailHdr,
  output logic [3*DAT_W-1:0]  o_AvailDat,
  output logic [3*STAT_W-1:0] o_StallCnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  localparam logic [HDR_W-1:0] HDR_HALF = {1'b1, {(HDR_W-1){1'b0}}};
  localparam logic [DAT_W-1:0] DAT_HALF = {1'b1, {(DAT_W-1){1'b0}}};

  state_t state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [DAT_W-1:0] need_q, need_d;

  logic [2:0][HDR_W-1:0] lim_hdr_q, lim_hdr_d;
  logic [2:0][DAT_W-1:0] lim_dat_q, lim_dat_d;
  logic [5:0]            inf_q, inf_d;
  logic [2:0][HDR_W-1:0] cons_hdr_q, cons_hdr_d;
  logic [2:0][DAT_W-1:0] cons_dat_q, cons_dat_d;

  logic [2:0] type_oh;
  logic [2:0] hdr_ok;
  logic [2:0] dat_ok;
  logic [2:0] suff_vec;
  logic       suff;
  logic       grant_now;
  logic       stall_now;
  logic [2:0] commit;

  logic [HDR_W-1:0] hdr_rem [3];
  logic [DAT_W-1:0] dat_rem [3];

  // Reserved type 3 decodes to no lane, so it can never be sufficient.
  assign type_oh = {type_q == 2'd2, type_q == 2'd1, type_q == 2'd0};

  always_comb begin
    for (int t = 0; t < 3; t++) begin
      hdr_rem[t]  = lim_hdr_q[t] - (cons_hdr_q[t] + {{(HDR_W-1){1'b0}}, 1'b1});
      dat_rem[t]  = lim_dat_q[t] - (cons_dat_q[t] + need_q);
      hdr_ok[t]   = inf_q[t] | (hdr_rem[t] <= HDR_HALF);
      dat_ok[t]   = inf_q[3+t] | (dat_rem[t] <= DAT_HALF);
      suff_vec[t] = hdr_ok[t] & ((need_q == '0) | dat_ok[t]);
    end
  end

  assign suff = |(suff_vec & type_oh);

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    need_d    = need_q;
    grant_now = 1'b0;
    stall_now = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_ReqVal) begin
          state_d = S_CHECK;
          type_d  = i_ReqType;
          need_d  = i_ReqDat;
        end
      end
      S_CHECK: begin
        if (suff) begin
          state_d   = S_GRANT;
          grant_now = 1'b1;
        end else begin
          stall_now = 1'b1;
        end
      end
      S_GRANT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign commit = type_oh & {3{grant_now}};

  // Grant commit and HIP single-credit consume land in the same step.
  always_comb begin
    for (int t = 0; t < 3; t++) begin
      cons_hdr_d[t] = cons_hdr_q[t]
                    + {{(HDR_W-1){1'b0}}, commit[t]}
                    + {{(HDR_W-1){1'b0}}, i_HipCons1[t]};
      cons_dat_d[t] = cons_dat_q[t]
                    + (commit[t] ? need_q : '0)
                    + {{(DAT_W-1){1'b0}}, i_HipCons1[3+t]};
    end
  end

  always_comb begin
    lim_hdr_d = lim_hdr_q;
    lim_dat_d = lim_dat_q;
    inf_d     = inf_q;
    if (i_LimLoad) begin
      lim_hdr_d = i_LimHdr;
      lim_dat_d = i_LimDat;
      inf_d     = i_LimInf;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_SClr) begin
      state_q    <= S_IDLE;
      type_q     <= '0;
      need_q     <= '0;
      lim_hdr_q  <= '0;
      lim_dat_q  <= '0;
      inf_q      <= '0;
      cons_hdr_q <= '0;
      cons_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      need_q     <= need_d;
      lim_hdr_q  <= lim_hdr_d;
      lim_dat_q  <= lim_dat_d;
      inf_q      <= inf_d;
      cons_hdr_q <= cons_hdr_d;
      cons_dat_q <= cons_dat_d;
    end
  end

  assign o_ReqGnt  = (state_q == S_GRANT);
  assign o_ConsHdr = cons_hdr_q;
  assign o_ConsDat = cons_dat_q;

  always_comb begin
    for (int t = 0; t < 3; t++) begin
      o_AvailHdr[t*HDR_W +: HDR_W] =
        inf_q[t] ? {HDR_W{1'b1}} : lim_hdr_q[t] - cons_hdr_q[t];
      o_AvailDat[t*DAT_W +: DAT_W] =
        inf_q[3+t] ? {DAT_W{1'b1}} : lim_dat_q[t] - cons_dat_q[t];
    end
  end

`ifdef TX_CREDIT_STALL_STATS_EN
  logic [2:0][STAT_W-1:0] stall_q, stall_d;

  always_comb begin
    for (int t = 0; t < 3; t++) begin
      stall_d[t] = stall_q[t];
      if (stall_now && type_oh[t] && !(&stall_q[t])) begin
        stall_d[t] = stall_q[t] + {{(STAT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_SClr) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_StallCnt = stall_q;
`else
  logic unused_stall;
  assign unused_stall = stall_now;
  assign o_StallCnt   = '0;
`endif

endmodule

// File: tb/tb_pcie_tx_credit_gate.sv
// Bench for pcie_tx_credit_gate: directed scenarios plus random traffic vs a credit model.
// Stall statistics are checked when TX_CREDIT_STALL_STATS_EN is defined.
module tb_pcie_tx_credit_gate;

  logic        clk = 1'b0;
  logic        sclr;
  logic        limload;
  logic [23:0] limhdr;
  logic [35:0] limdat;
  logic [5:0]  liminf;
  logic [5:0]  hip;
  logic        reqval;
  logic [1:0]  reqtype;
  logic [11:0] reqdat;
  logic        gnt;
  logic [23:0] conshdr;
  logic [35:0] consdat;
  logic [23:0] availhdr;
  logic [35:0] availdat;
  logic [47:0] stallcnt;

  int tests = 0;
  int fails = 0;

  int mlh[3];
  int mld[3];
  int mch[3];
  int mcd[3];
  bit minf[6];

  pcie_tx_credit_gate dut (
    .i_Clk      (clk),
    .i_SClr     (sclr),
    .i_LimLoad  (limload),
    .i_LimHdr   (limhdr),
    .i_LimDat   (limdat),
    .i_LimInf   (liminf),
    .i_HipCons1 (hip),
    .i_ReqVal   (reqval),
    .i_ReqType  (reqtype),
    .i_ReqDat   (reqdat),
    .o_ReqGnt   (gnt),
    .o_ConsHdr  (conshdr),
    .o_ConsDat  (consdat),
    .o_AvailHdr (availhdr),
    .o_AvailDat (availdat),
    .o_StallCnt (stallcnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset;
    for (int t = 0; t < 3; t++) begin
      mlh[t] = 0; mld[t] = 0; mch[t] = 0; mcd[t] = 0;
    end
    for (int i = 0; i < 6; i++) minf[i] = 1'b0;
  endfunction

  function automatic bit m_ok(input int t, input int d);
    bit h;
    bit dd;
    if (t > 2) return 1'b0;
    h  = minf[t] || (((mlh[t] - mch[t] - 1) & 255) <= 128);
    dd = (d == 0) || minf[3+t] || (((mld[t] - mcd[t] - d) & 4095) <= 2048);
    return h && dd;
  endfunction

  function automatic void m_commit(input int t, input int d);
    mch[t] = (mch[t] + 1) & 255;
    mcd[t] = (mcd[t] + d) & 4095;
  endfunction

  function automatic void m_hip(input logic [5:0] b);
    for (int t = 0; t < 3; t++) begin
      mch[t] = (mch[t] + int'(b[t])) & 255;
      mcd[t] = (mcd[t] + int'(b[3+t])) & 4095;
    end
  endfunction

  task automatic do_reset;
    sclr    = 1'b1;
    reqval  = 1'b0;
    limload = 1'b0;
    hip     = '0;
    tick();
    sclr = 1'b0;
    m_reset();
  endtask

  task automatic load_lims;
    for (int t = 0; t < 3; t++) begin
      limhdr[t*8 +: 8]   = 8'(mlh[t]);
      limdat[t*12 +: 12] = 12'(mld[t]);
    end
    for (int i = 0; i < 6; i++) liminf[i] = minf[i];
    limload = 1'b1;
    tick();
    limload = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [23:0] eh, ah;
    logic [35:0] ed, ad;
    for (int t = 0; t < 3; t++) begin
      eh[t*8 +: 8]   = 8'(mch[t]);
      ed[t*12 +: 12] = 12'(mcd[t]);
      ah[t*8 +: 8]   = minf[t] ? 8'hFF : 8'(mlh[t] - mch[t]);
      ad[t*12 +: 12] = minf[3+t] ? 12'hFFF : 12'(mld[t] - mcd[t]);
    end
    chk({tag, ".conshdr"}, 64'(conshdr), 64'(eh));
    chk({tag, ".consdat"}, 64'(consdat), 64'(ed));
    chk({tag, ".availhdr"}, 64'(availhdr), 64'(ah));
    chk({tag, ".availdat"}, 64'(availdat), 64'(ad));
`ifndef TX_CREDIT_STALL_STATS_EN
    chk({tag, ".stall"}, 64'(stallcnt), 64'd0);
`endif
  endtask

  // Raise a request and wait up to maxc cycles; lat is the grant cycle or -1.
  task automatic req_wait(input int t, input int d, input int maxc,
                          output int lat);
    reqtype = 2'(t);
    reqdat  = 12'(d);
    reqval  = 1'b1;
    lat     = -1;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      if (gnt === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat >= 0) begin
      reqval = 1'b0;
      tick();
      chk("gnt_pulse", 64'(gnt), 64'd0);
    end
  endtask

  initial begin
    int lat;
    int r, t, d, n;
    bit e;
    logic [5:0] hb;
    sclr = 1'b0; limload = 1'b0; limhdr = '0; limdat = '0;
    liminf = '0; hip = '0; reqval = 1'b0; reqtype = '0; reqdat = '0;
    m_reset();

    do_reset();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_stall", 64'(stallcnt), 64'd0);
    check_state("rst");

    req_wait(0, 0, 5, lat);
    chk("nolim_stall", 64'(lat), 64'(-1));
    mlh[0] = 1;
    load_lims();
    chk("load_gnt_early", 64'(gnt), 64'd0);
    tick();
    chk("load_gnt", 64'(gnt), 64'd1);
    m_commit(0, 0);
    reqval = 1'b0;
    tick();
    check_state("load");
    chk("load_conshdr_p", 64'(conshdr[7:0]), 64'd1);

    do_reset();
    mlh[0] = 4; mld[0] = 8;
    load_lims();
    req_wait(0, 9, 6, lat);
    chk("dat9_stall", 64'(lat), 64'(-1));
    do_reset();
    mlh[0] = 4; mld[0] = 8;
    load_lims();
    req_wait(0, 8, 4, lat);
    chk("dat8_lat", 64'(lat), 64'd2);
    m_commit(0, 8);
    check_state("dat8");
    chk("dat8_avail", 64'(availdat[11:0]), 64'd0);

    do_reset();
    minf[1] = 1'b1;
    load_lims();
    hip = 6'b000010;
    repeat (255) tick();
    hip = '0;
    mch[1] = 255;
    chk("nh_ff", 64'(conshdr[15:8]), 64'hFF);
    minf[1] = 1'b0; mlh[1] = 1;
    load_lims();
    req_wait(1, 0, 4, lat);
    chk("nh_wrap_lat", 64'(lat), 64'd2);
    m_commit(1, 0);
    check_state("nh_wrap");
    chk("nh_avail", 64'(availhdr[15:8]), 64'd1);

    mlh[2] = 10; mld[2] = 100;
    load_lims();
    reqtype = 2'd2; reqdat = 12'd3; reqval = 1'b1;
    tick();
    hip = 6'b100100;
    tick();
    hip = '0;
    chk("cpl_hip_gnt", 64'(gnt), 64'd1);
    m_commit(2, 3);
    m_hip(6'b100100);
    reqval = 1'b0;
    tick();
    check_state("cpl_hip");
    chk("cpl_hip_dat", 64'(consdat[35:24]), 64'd4);
    chk("cpl_hip_hdr", 64'(conshdr[23:16]), 64'd2);

    for (int i = 0; i < 6; i++) minf[i] = 1'b1;
    load_lims();
    req_wait(3, 0, 6, lat);
    chk("type3_stall", 64'(lat), 64'(-1));

    do_reset();
    minf[0] = 1'b1; mlh[0] = 0;
    load_lims();
    for (int i = 0; i < 300; i++) begin
      req_wait(0, 0, 4, lat);
      chk("inf_lat", 64'(lat), 64'd2);
      m_commit(0, 0);
    end
    check_state("inf300");
    chk("inf_conshdr", 64'(conshdr[7:0]), 64'd44);
    chk("inf_avail", 64'(availhdr[7:0]), 64'hFF);

    do_reset();
    req_wait(0, 0, 4, lat);
    chk("abort_stall", 64'(lat), 64'(-1));
`ifdef TX_CREDIT_STALL_STATS_EN
    chk("stall_p3", 64'(stallcnt[15:0]), 64'd3);
`endif
    sclr = 1'b1; reqval = 1'b0;
    tick();
    sclr = 1'b0;
    m_reset();
    chk("abort_gnt", 64'(gnt), 64'd0);
    chk("abort_stallcnt", 64'(stallcnt), 64'd0);
    check_state("abort");
    tick(); tick();
    chk("abort_gnt2", 64'(gnt), 64'd0);
    mlh[0] = 1;
    load_lims();
    req_wait(0, 0, 4, lat);
    chk("abort_idle_lat", 64'(lat), 64'd2);
    m_commit(0, 0);
    check_state("abort_after");

    do_reset();
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        for (int k = 0; k < 3; k++) begin
          mlh[k] = $urandom_range(0, 255);
          mld[k] = $urandom_range(0, 4095);
        end
        for (int k = 0; k < 6; k++) minf[k] = ($urandom_range(0, 7) == 0);
        load_lims();
        check_state("rnd_load");
      end else if (r == 1) begin
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
          hb = 6'($urandom_range(0, 63));
          hip = hb;
          tick();
          m_hip(hb);
        end
        hip = '0;
        check_state("rnd_hip");
      end else begin
        t = $urandom_range(0, 2);
        d = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 64);
        e = m_ok(t, d);
        req_wait(t, d, 4, lat);
        if (e) begin
          chk("rnd_lat", 64'(lat), 64'd2);
        end else begin
          chk("rnd_stall", 64'(lat), 64'(-1));
          minf[t] = 1'b1; minf[3+t] = 1'b1;
          load_lims();
          tick();
          chk("rnd_unblock", 64'(gnt), 64'd1);
          reqval = 1'b0;
          tick();
        end
        m_commit(t, d);
        check_state("rnd_req");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
